instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter INST_W, default 16, meaning instruction width in bits.
REQ-002 The block SHALL have parameter I_ADDR_W, default 12, meaning instruction address width in bits.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port pc, input, I_ADDR_W, current program counter value.
REQ-006 The block SHALL have port stall, input, 1, execute stage cannot accept the held instruction this cycle.
REQ-007 The block SHALL have port flush, input, 1, redirect pulse; discard any held or in-flight instruction.
REQ-008 The block SHALL have port imem_req, output, 1, instruction memory request.
REQ-009 The block SHALL have port imem_addr, output, I_ADDR_W, instruction memory address.
REQ-010 The block SHALL have port imem_ready, input, 1, imem_rdata valid this cycle.
REQ-011 The block SHALL have port imem_rdata, input, INST_W, instruction memory read data.
REQ-012 The block SHALL have port instruction, output, INST_W, instruction register contents, driving the decoder.
REQ-013 The block SHALL have port instruction_valid, output, 1, instruction register holds a live instruction.
REQ-014 The block SHALL have port fetch_pc, output, I_ADDR_W, address the held instruction was fetched from.
REQ-015 The block SHALL have port pc_advance, output, 1, one-cycle pulse telling the program counter to step.

Function
REQ-016 The block SHALL implement states IDLE, REQUEST, HOLD, all registered.
REQ-017 IDLE SHALL transition to REQUEST unconditionally on the next edge.
REQ-018 In REQUEST, imem_req SHALL be 1 and imem_addr SHALL equal pc combinationally; in all other states, imem_req=0 and imem_addr=0.
REQ-019 In REQUEST with imem_ready=1 and flush=0: instruction<=imem_rdata, fetch_pc<=pc, state<=HOLD; instruction_valid=1 from the next cycle.
REQ-020 In REQUEST with imem_ready=0 and flush=0: stay in REQUEST, hold req and addr; wait cycles are unbounded.
REQ-021 In REQUEST with flush=1: discard imem_rdata even when imem_ready=1, and go to IDLE.
REQ-022 stall SHALL be ignored in IDLE and REQUEST.
REQ-023 In HOLD with stall=0 and flush=0: pc_advance=1 this cycle, instruction_valid<=0, state<=REQUEST.
REQ-024 In HOLD with stall=1 and flush=0: stay in HOLD; instruction, fetch_pc and instruction_valid unchanged; pc_advance=0.
REQ-025 In HOLD with flush=1: flush has priority over stall and consumption; pc_advance=0, instruction_valid<=0, state<=IDLE.
REQ-026 pc_advance SHALL be combinational from state, stall and flush, and SHALL be asserted only in HOLD.
REQ-027 instruction_valid SHALL be 1 exactly when state is HOLD.
REQ-028 instruction SHALL keep its last value when invalid; consumers qualify it with instruction_valid.
REQ-029 Throughput with a zero-wait memory and no stall SHALL be one instruction per 2 cycles.
REQ-030 fetch_pc SHALL wrap naturally at I_ADDR_W bits; the block performs no PC arithmetic.

Reset
REQ-031 With reset=1 at an edge: state<=IDLE, instruction<=0, fetch_pc<=0, instruction_valid=0, pc_advance=0, imem_req=0.
REQ-032 reset SHALL override flush, stall and imem_ready, including mid-request; a memory response in the reset cycle is dropped.

Configuration
REQ-033 With macro INSTRUCTION_FETCH_PERF_EN defined: add outputs fetch_count[15:0] and wait_count[15:0], both reset to 0.
REQ-034 fetch_count SHALL increment on each REQ-019 capture, and wait_count on each REQUEST cycle with imem_ready=0; both saturate at 0xFFFF.
REQ-035 With INSTRUCTION_FETCH_PERF_EN undefined: these ports and counters SHALL be absent and behaviour is otherwise identical.

Verification
REQ-036 Bench: reset, then pc=0x010, imem_ready=1, rdata=0x1234 -> req in cycle 1 with addr 0x010; cycle 2 valid=1, instruction=0x1234, fetch_pc=0x010, pc_advance=1.
REQ-037 Bench: imem_ready=0 for 3 REQUEST cycles, then 1 with rdata=0xBEEF -> req held for 4 cycles at a stable addr, then valid with 0xBEEF; wait_count=3 when PERF_EN is defined.
REQ-038 Bench: HOLD with stall=1 for 5 cycles -> instruction stable, pc_advance=0 all 5 cycles; the first cycle with stall=0 gives pc_advance=1.
REQ-039 Bench: flush=1 together with imem_ready=1 and rdata=0xAAAA -> valid stays 0; IDLE then REQUEST; 0xAAAA is never presented.
REQ-040 Bench: flush=1 and stall=1 in HOLD -> pc_advance=0; valid=0 on the next cycle; state is IDLE.
REQ-041 Bench: reset asserted mid-REQUEST with imem_ready=1 -> all outputs are at reset values on the next cycle; fetch_count=0.

Source files
------------

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - single-entry instruction fetch stage between imem and decode
//
// Purpose:
//   Requests one instruction at a time from instruction memory at the address
//   presented on pc, captures the returned word into the instruction register,
//   and holds it for the execute stage until it is consumed (stall low), at
//   which point the program counter is told to step via pc_advance.
//
// Ports:
//   clk               - single clock, rising-edge
//   reset             - synchronous active-high reset
//   pc                - current program counter value
//   stall             - execute cannot take the held instruction this cycle
//   flush             - redirect pulse, drops held or in-flight instruction
//   imem_req          - instruction memory request (REQUEST state only)
//   imem_addr         - instruction memory address (pc while requesting, else 0)
//   imem_ready        - imem_rdata valid this cycle
//   imem_rdata        - instruction memory read data
//   instruction       - instruction register contents
//   instruction_valid - instruction register holds a live instruction
//   fetch_pc          - address the held instruction came from
//   pc_advance        - one-cycle pulse telling the program counter to step
//   fetch_count       - captured instructions, saturating (perf build only)
//   wait_count        - REQUEST cycles without imem_ready, saturating (perf build only)
//
// Configuration:
//   INSTRUCTION_FETCH_PERF_EN - when defined, adds the fetch_count/wait_count
//   performance counters and their output ports.

module instruction_fetch #(
    parameter int INST_W   = 16,
    parameter int I_ADDR_W = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [I_ADDR_W-1:0] pc,
    input  logic                stall,
    input  logic                flush,
    output logic                imem_req,
    output logic [I_ADDR_W-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [INST_W-1:0]   imem_rdata,
    output logic [INST_W-1:0]   instruction,
    output logic                instruction_valid,
    output logic [I_ADDR_W-1:0] fetch_pc,
    output logic                pc_advance
`ifdef INSTRUCTION_FETCH_PERF_EN
    ,
    output logic [15:0]         fetch_count,
    output logic [15:0]         wait_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQUEST = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   capture;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush always wins: in REQUEST it drops the response, in HOLD it drops
    // the held word without advancing the PC, so the redirected pc is fetched
    // fresh after one IDLE cycle.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        imem_addr  = '0;
        pc_advance = 1'b0;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = S_REQUEST;
            end
            S_REQUEST: begin
                imem_req  = 1'b1;
                imem_addr = pc;
                if (flush) begin
                    state_next = S_IDLE;
                end else if (imem_ready) begin
                    capture    = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_next = S_IDLE;
                end else if (!stall) begin
                    pc_advance = 1'b1;
                    state_next = S_REQUEST;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // The instruction register keeps its last word when invalid; consumers
    // qualify it with instruction_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            instruction <= '0;
            fetch_pc    <= '0;
        end else if (capture) begin
            instruction <= imem_rdata;
            fetch_pc    <= pc;
        end
    end

    assign instruction_valid = (state == S_HOLD);

`ifdef INSTRUCTION_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
            wait_count  <= '0;
        end else begin
            if (capture && (fetch_count != 16'hFFFF)) begin
                fetch_count <= fetch_count + 16'd1;
            end
            if ((state == S_REQUEST) && !imem_ready && (wait_count != 16'hFFFF)) begin
                wait_count <= wait_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch

module tb_instruction_fetch;

    localparam int INST_W   = 16;
    localparam int I_ADDR_W = 12;

    logic                clk = 1'b0;
    logic                reset;
    logic [I_ADDR_W-1:0] pc;
    logic                stall;
    logic                flush;
    logic                imem_req;
    logic [I_ADDR_W-1:0] imem_addr;
    logic                imem_ready;
    logic [INST_W-1:0]   imem_rdata;
    logic [INST_W-1:0]   instruction;
    logic                instruction_valid;
    logic [I_ADDR_W-1:0] fetch_pc;
    logic                pc_advance;
`ifdef INSTRUCTION_FETCH_PERF_EN
    logic [15:0]         fetch_count;
    logic [15:0]         wait_count;
`endif

    instruction_fetch #(.INST_W(INST_W), .I_ADDR_W(I_ADDR_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .pc                (pc),
        .stall             (stall),
        .flush             (flush),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_rdata        (imem_rdata),
        .instruction       (instruction),
        .instruction_valid (instruction_valid),
        .fetch_pc          (fetch_pc),
        .pc_advance        (pc_advance)
`ifdef INSTRUCTION_FETCH_PERF_EN
        ,
        .fetch_count       (fetch_count),
        .wait_count        (wait_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: "fetching" means a memory request is outstanding,
    // "holding" means a live word sits in the instruction register; neither
    // means the one idle cycle after reset or flush.
    bit          model_on = 1'b0;
    bit          m_fetching = 1'b0;
    bit          m_holding = 1'b0;
    logic [15:0] m_instr = '0;
    logic [11:0] m_fpc = '0;
    int          m_fetches = 0;
    int          m_waits = 0;

    always @(posedge clk) begin
        if (reset) begin
            model_on   = 1'b1;
            m_fetching = 1'b0;
            m_holding  = 1'b0;
            m_instr    = '0;
            m_fpc      = '0;
            m_fetches  = 0;
            m_waits    = 0;
        end else if (m_fetching) begin
            if (!imem_ready && m_waits < 65535) m_waits++;
            if (flush) begin
                m_fetching = 1'b0;
            end else if (imem_ready) begin
                m_instr    = imem_rdata;
                m_fpc      = pc;
                m_fetching = 1'b0;
                m_holding  = 1'b1;
                if (m_fetches < 65535) m_fetches++;
            end
        end else if (m_holding) begin
            if (flush) begin
                m_holding = 1'b0;
            end else if (!stall) begin
                m_holding  = 1'b0;
                m_fetching = 1'b1;
            end
        end else begin
            m_fetching = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("imem_req", 32'(imem_req), 32'(m_fetching));
            chk("imem_addr", 32'(imem_addr), m_fetching ? 32'(pc) : 32'd0);
            chk("instruction_valid", 32'(instruction_valid), 32'(m_holding));
            chk("pc_advance", 32'(pc_advance), 32'(m_holding && !stall && !flush));
            chk("instruction", 32'(instruction), 32'(m_instr));
            chk("fetch_pc", 32'(fetch_pc), 32'(m_fpc));
`ifdef INSTRUCTION_FETCH_PERF_EN
            chk("fetch_count", 32'(fetch_count), 32'(m_fetches));
            chk("wait_count", 32'(wait_count), 32'(m_waits));
`endif
        end
    end

    task automatic drive(input logic rst, input logic rdy, input logic [15:0] rd,
                         input logic [11:0] p, input logic st, input logic fl);
        reset      = rst;
        imem_ready = rdy;
        imem_rdata = rd;
        pc         = p;
        stall      = st;
        flush      = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 16'h0, 12'h0, 1'b0, 1'b0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_valid", 32'(instruction_valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_instr", 32'(instruction), 32'd0);
        chk("rst_fpc", 32'(fetch_pc), 32'd0);
        chk("rst_adv", 32'(pc_advance), 32'd0);
        next_cycle();

        // Zero-wait fetch: IDLE, REQUEST, HOLD.
        drive(1'b0, 1'b1, 16'h1234, 12'h010, 1'b0, 1'b0);
        @(negedge clk);
        chk("c0_req", 32'(imem_req), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("c1_req", 32'(imem_req), 32'd1);
        chk("c1_addr", 32'(imem_addr), 32'h010);
        next_cycle();
        drive(1'b0, 1'b0, 16'h0, 12'h020, 1'b0, 1'b0);
        @(negedge clk);
        chk("c2_valid", 32'(instruction_valid), 32'd1);
        chk("c2_instr", 32'(instruction), 32'h1234);
        chk("c2_fpc", 32'(fetch_pc), 32'h010);
        chk("c2_adv", 32'(pc_advance), 32'd1);
        next_cycle();

        // Three wait cycles, then a response.
        for (int i = 0; i < 4; i++) begin
            if (i == 3) drive(1'b0, 1'b1, 16'hBEEF, 12'h020, 1'b0, 1'b0);
            @(negedge clk);
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", 32'(imem_addr), 32'h020);
            next_cycle();
        end
        drive(1'b0, 1'b0, 16'h0, 12'h020, 1'b1, 1'b0);
        @(negedge clk);
        chk("beef_valid", 32'(instruction_valid), 32'd1);
        chk("beef_instr", 32'(instruction), 32'hBEEF);
`ifdef INSTRUCTION_FETCH_PERF_EN
        chk("lit_wait_count", 32'(wait_count), 32'd3);
        chk("lit_fetch_count", 32'(fetch_count), 32'd2);
`endif

        // Five stalled HOLD cycles, then consumption.
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            chk("stall_instr", 32'(instruction), 32'hBEEF);
            chk("stall_adv", 32'(pc_advance), 32'd0);
            next_cycle();
        end
        drive(1'b0, 1'b0, 16'h0, 12'h030, 1'b0, 1'b0);
        @(negedge clk);
        chk("unstall_adv", 32'(pc_advance), 32'd1);
        next_cycle();

        // Flush coincident with a memory response.
        drive(1'b0, 1'b1, 16'hAAAA, 12'h030, 1'b0, 1'b1);
        @(negedge clk);
        chk("fl_req", 32'(imem_req), 32'd1);
        next_cycle();
        drive(1'b0, 1'b0, 16'h0, 12'h030, 1'b0, 1'b0);
        @(negedge clk);
        chk("fl_idle_req", 32'(imem_req), 32'd0);
        chk("fl_valid", 32'(instruction_valid), 32'd0);
        chk("fl_instr", 32'(instruction), 32'hBEEF);
        next_cycle();
        drive(1'b0, 1'b1, 16'h5678, 12'h030, 1'b0, 1'b0);
        @(negedge clk);
        chk("fl_rereq", 32'(imem_req), 32'd1);
        next_cycle();

        // Flush and stall together in HOLD.
        drive(1'b0, 1'b0, 16'h0, 12'h030, 1'b1, 1'b1);
        @(negedge clk);
        chk("fs_valid", 32'(instruction_valid), 32'd1);
        chk("fs_adv", 32'(pc_advance), 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 16'h0, 12'hFFF, 1'b0, 1'b0);
        @(negedge clk);
        chk("fs_next_valid", 32'(instruction_valid), 32'd0);
        chk("fs_next_req", 32'(imem_req), 32'd0);
        next_cycle();

        // Top-of-range address.
        drive(1'b0, 1'b1, 16'h9ABC, 12'hFFF, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, 16'h0, 12'h040, 1'b0, 1'b0);
        @(negedge clk);
        chk("top_fpc", 32'(fetch_pc), 32'hFFF);
        chk("top_instr", 32'(instruction), 32'h9ABC);
        next_cycle();

        // Reset mid-REQUEST with a response present.
        drive(1'b1, 1'b1, 16'h1111, 12'h040, 1'b1, 1'b1);
        @(negedge clk);
        chk("mr_req", 32'(imem_req), 32'd1);
        next_cycle();
        drive(1'b0, 1'b0, 16'h0, 12'h040, 1'b0, 1'b0);
        @(negedge clk);
        chk("mr_valid", 32'(instruction_valid), 32'd0);
        chk("mr_req_after", 32'(imem_req), 32'd0);
        chk("mr_instr", 32'(instruction), 32'd0);
        chk("mr_fpc", 32'(fetch_pc), 32'd0);
        chk("mr_adv", 32'(pc_advance), 32'd0);
`ifdef INSTRUCTION_FETCH_PERF_EN
        chk("mr_fetch_count", 32'(fetch_count), 32'd0);
`endif
        next_cycle();

        // Mixed traffic, checked by the model only.
        for (int i = 0; i < 60; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 12'($urandom),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
            next_cycle();
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
